// File: rtl/dma_ctrl_if.sv
// rtl/dma_ctrl_if.sv - DMA control, SRAM and DRAM signal bundle between core, DMA and memories
interface dma_ctrl_if #(parameter int WIDTH_BITS = 10);
   logic [1:0]            dmaCmd;
   logic [31:0]           dmaSrcAddress;
   logic [31:0]           dmaDstAddress;
   logic [WIDTH_BITS-1:0] dmaWidth;
   logic                  stall;
   logic                  dmaValid;
   logic [31:0]           coreSramAddress;
   logic [31:0]           coreSramWriteData;
   logic                  coreSramWriteEnable;
   logic [31:0]           sramAddress;
   logic [31:0]           sramWriteData;
   logic                  sramWriteEnable;
   logic [31:0]           sramReadData;
   logic                  dramReq;
   logic                  dramWe;
   logic [31:0]           dramAddress;
   logic [31:0]           dramWriteData;
   logic                  dramAck;
   logic [31:0]           dramReadData;

   modport master (
      input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
      input  coreSramAddress, coreSramWriteData, coreSramWriteEnable,
      input  sramReadData, dramAck, dramReadData,
      output stall, dmaValid, sramAddress, sramWriteData, sramWriteEnable,
      output dramReq, dramWe, dramAddress, dramWriteData
   );

   modport slave (
      output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
      output coreSramAddress, coreSramWriteData, coreSramWriteEnable,
      output sramReadData, dramAck, dramReadData,
      input  stall, dmaValid, sramAddress, sramWriteData, sramWriteEnable,
      input  dramReq, dramWe, dramAddress, dramWriteData
   );
endinterface

// File: rtl/dma_ctrl.sv
// rtl/dma_ctrl.sv - single-channel word-at-a-time DMA between scratchpad SRAM and DRAM
module dma_ctrl #(
   parameter int WIDTH_BITS = 10
) (
   input logic       clk,
   input logic       reset,
   dma_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_REQ, DONE
   } state_t;

   state_t                state;
   logic [31:0]           src;
   logic [31:0]           dst;
   logic [WIDTH_BITS-1:0] count;
   logic [31:0]           word;
   logic                  stall_q;
   logic                  valid_q;
   logic                  req_q;
   logic                  we_q;
   logic [31:0]           daddr_q;
   logic [31:0]           wdata_q;

   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // All DRAM-side outputs are loaded together with the state they belong to,
   // so they stay constant for the whole request and need no decode logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         src     <= '0;
         dst     <= '0;
         count   <= '0;
         word    <= '0;
         stall_q <= 1'b0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         daddr_q <= '0;
         wdata_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.dmaCmd == 2'b01 || bus.dmaCmd == 2'b10) begin
                  src   <= bus.dmaSrcAddress;
                  dst   <= bus.dmaDstAddress;
                  count <= bus.dmaWidth;
                  if (bus.dmaWidth == '0) begin
                     state   <= DONE;
                     valid_q <= 1'b1;
                  end else if (bus.dmaCmd == 2'b01) begin
                     state   <= D2S_REQ;
                     stall_q <= 1'b1;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     daddr_q <= align(bus.dmaSrcAddress);
                  end else begin
                     state   <= S2D_RD;
                     stall_q <= 1'b1;
                  end
               end
            end
            D2S_REQ: begin
               if (bus.dramAck) begin
                  word  <= bus.dramReadData;
                  req_q <= 1'b0;
                  state <= D2S_WR;
               end
            end
            D2S_WR: begin
               src   <= src + 32'd4;
               dst   <= dst + 32'd4;
               count <= count - 1'b1;
               if (count == WIDTH_BITS'(1)) begin
                  state   <= DONE;
                  stall_q <= 1'b0;
                  valid_q <= 1'b1;
               end else begin
                  state   <= D2S_REQ;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  daddr_q <= align(src + 32'd4);
               end
            end
            S2D_RD: begin
               state   <= S2D_REQ;
               req_q   <= 1'b1;
               we_q    <= 1'b1;
               daddr_q <= align(dst);
               wdata_q <= bus.sramReadData;
            end
            S2D_REQ: begin
               if (bus.dramAck) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  src   <= src + 32'd4;
                  dst   <= dst + 32'd4;
                  count <= count - 1'b1;
                  if (count == WIDTH_BITS'(1)) begin
                     state   <= DONE;
                     stall_q <= 1'b0;
                     valid_q <= 1'b1;
                  end else begin
                     state <= S2D_RD;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               stall_q <= 1'b0;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   // The core owns the SRAM port in IDLE and DONE; the DMA owns it otherwise.
   always_comb begin
      bus.sramAddress     = bus.coreSramAddress;
      bus.sramWriteData   = bus.coreSramWriteData;
      bus.sramWriteEnable = bus.coreSramWriteEnable;
      case (state)
         D2S_REQ: begin
            bus.sramAddress     = align(dst);
            bus.sramWriteData   = word;
            bus.sramWriteEnable = 1'b0;
         end
         D2S_WR: begin
            bus.sramAddress     = align(dst);
            bus.sramWriteData   = word;
            bus.sramWriteEnable = 1'b1;
         end
         S2D_RD, S2D_REQ: begin
            bus.sramAddress     = align(src);
            bus.sramWriteData   = '0;
            bus.sramWriteEnable = 1'b0;
         end
         default: begin
         end
      endcase
   end

   assign bus.stall         = stall_q;
   assign bus.dmaValid      = valid_q;
   assign bus.dramReq       = req_q;
   assign bus.dramWe        = we_q;
   assign bus.dramAddress   = daddr_q;
   assign bus.dramWriteData = wdata_q;
endmodule

// File: tb/tb_dma_ctrl.sv
// tb/tb_dma_ctrl.sv - directed self-checking bench for dma_ctrl with SRAM and DRAM models
module tb_dma_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dma_ctrl_if #(.WIDTH_BITS(10)) bus();
   dma_ctrl #(.WIDTH_BITS(10)) dut (.clk(clk), .reset(reset), .bus(bus.master));

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] sram_mem [256];
   logic [31:0] dram_mem [256];
   int          dram_lat = 1;
   int          wcnt = 0;

   logic [31:0] rd_log [64];
   logic [31:0] wa_log [64];
   logic [31:0] wd_log [64];
   int          rd_n = 0;
   int          wr_n = 0;
   int          sram_wr_cnt = 0;
   int          req_cyc_cnt = 0;
   int          stab_err = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr, pend_data;
   logic        pend_we;

   always_comb bus.sramReadData = sram_mem[bus.sramAddress[9:2]];
   always_comb bus.dramAck      = bus.dramReq && (wcnt >= dram_lat - 1);
   always_comb bus.dramReadData = dram_mem[bus.dramAddress[9:2]];

   always @(posedge clk) begin
      if (bus.sramWriteEnable) begin
         sram_mem[bus.sramAddress[9:2]] <= bus.sramWriteData;
         sram_wr_cnt <= sram_wr_cnt + 1;
      end
      if (reset || !bus.dramReq || bus.dramAck) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (bus.dramReq) req_cyc_cnt <= req_cyc_cnt + 1;
      if (!reset && bus.dramReq && bus.dramAck) begin
         if (bus.dramWe) begin
            if (wr_n < 64) begin
               wa_log[wr_n] <= bus.dramAddress;
               wd_log[wr_n] <= bus.dramWriteData;
            end
            wr_n <= wr_n + 1;
         end else begin
            if (rd_n < 64) rd_log[rd_n] <= bus.dramAddress;
            rd_n <= rd_n + 1;
         end
      end
      // A pending request must present the same address, direction and data until acked.
      if (pend && bus.dramReq &&
          (bus.dramAddress !== pend_addr || bus.dramWe !== pend_we || bus.dramWriteData !== pend_data))
         stab_err <= stab_err + 1;
      pend      <= bus.dramReq && !bus.dramAck && !reset;
      pend_addr <= bus.dramAddress;
      pend_we   <= bus.dramWe;
      pend_data <= bus.dramWriteData;
   end

   task automatic core_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.coreSramAddress     = a;
      bus.coreSramWriteData   = d;
      bus.coreSramWriteEnable = 1'b1;
      @(negedge clk);
      bus.coreSramWriteEnable = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] s, input logic [31:0] d,
                          input logic [9:0] w, input int ncyc,
                          output int st, output int va, output int vc);
      @(negedge clk);
      bus.dmaCmd        = cmd;
      bus.dmaSrcAddress = s;
      bus.dmaDstAddress = d;
      bus.dmaWidth      = w;
      st = 0; va = -1; vc = 0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) bus.dmaCmd = 2'b00;
         if (bus.stall) st++;
         if (bus.dmaValid) begin
            vc++;
            if (va < 0) va = k;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      bus.coreSramAddress = 32'h0000_0124;
      bus.coreSramWriteData = 32'h1234_5678;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      n_checks++; if (bus.dmaValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.dmaValid); end
      n_checks++; if (bus.dramReq !== 1'b0 || bus.dramWe !== 1'b0) begin n_fail++; $display("FAIL reset_req_we: got %b%b want 00", bus.dramReq, bus.dramWe); end
      n_checks++; if (bus.dramAddress !== 32'h0 || bus.dramWriteData !== 32'h0) begin n_fail++; $display("FAIL reset_dram_bus: got %h/%h want 0/0", bus.dramAddress, bus.dramWriteData); end
      n_checks++; if (bus.sramAddress !== 32'h0000_0124 || bus.sramWriteData !== 32'h1234_5678 || bus.sramWriteEnable !== 1'b0) begin
         n_fail++; $display("FAIL reset_passthru: got %h/%h/%b want 00000124/12345678/0", bus.sramAddress, bus.sramWriteData, bus.sramWriteEnable); end
   endtask

   task automatic test_d2s;
      int st, va, vc, rb;
      dram_lat = 1;
      rb = rd_n;
      run_cmd(2'b01, 32'h100, 32'h40, 10'd4, 30, st, va, vc);
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (sram_mem[16+i] !== 32'hA0 + i) begin n_fail++; $display("FAIL d2s_word%0d: got %h want %h", i, sram_mem[16+i], 32'hA0 + i); end
         n_checks++; if (rd_log[rb+i] !== 32'h100 + 4*i) begin n_fail++; $display("FAIL d2s_rdaddr%0d: got %h want %h", i, rd_log[rb+i], 32'h100 + 4*i); end
      end
      n_checks++; if (st != 8) begin n_fail++; $display("FAIL d2s_stall_cycles: got %0d want 8", st); end
      n_checks++; if (va != 9 || vc != 1) begin n_fail++; $display("FAIL d2s_valid: got at %0d x%0d want at 9 x1", va, vc); end
   endtask

   task automatic test_s2d;
      int st, va, vc, wb, se;
      core_write(32'h20, 32'hCAFE_0001);
      core_write(32'h24, 32'hCAFE_0002);
      core_write(32'h28, 32'hCAFE_0003);
      dram_lat = 3;
      wb = wr_n;
      se = stab_err;
      run_cmd(2'b10, 32'h20, 32'h2000, 10'd3, 30, st, va, vc);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (wa_log[wb+i] !== 32'h2000 + 4*i || wd_log[wb+i] !== 32'hCAFE_0001 + i) begin
            n_fail++; $display("FAIL s2d_write%0d: got %h<-%h want %h<-%h", i, wa_log[wb+i], wd_log[wb+i], 32'h2000 + 4*i, 32'hCAFE_0001 + i); end
      end
      n_checks++; if (wr_n - wb != 3) begin n_fail++; $display("FAIL s2d_write_count: got %0d want 3", wr_n - wb); end
      n_checks++; if (stab_err != se) begin n_fail++; $display("FAIL s2d_req_stable: got %0d changes want 0", stab_err - se); end
      n_checks++; if (st != 12) begin n_fail++; $display("FAIL s2d_stall_cycles: got %0d want 12", st); end
      n_checks++; if (va != 13 || vc != 1) begin n_fail++; $display("FAIL s2d_valid: got at %0d x%0d want at 13 x1", va, vc); end
      dram_lat = 1;
   endtask

   task automatic test_zero_and_illegal;
      int st, va, vc, rq, sw;
      rq = req_cyc_cnt; sw = sram_wr_cnt;
      run_cmd(2'b01, 32'h100, 32'h40, 10'd0, 10, st, va, vc);
      n_checks++; if (st != 0) begin n_fail++; $display("FAIL zero_stall: got %0d cycles want 0", st); end
      n_checks++; if (va != 1 || vc != 1) begin n_fail++; $display("FAIL zero_valid: got at %0d x%0d want at 1 x1", va, vc); end
      n_checks++; if (req_cyc_cnt != rq || sram_wr_cnt != sw) begin n_fail++; $display("FAIL zero_activity: got req %0d wr %0d want 0 0", req_cyc_cnt - rq, sram_wr_cnt - sw); end
      rq = req_cyc_cnt; sw = sram_wr_cnt;
      run_cmd(2'b11, 32'h100, 32'h40, 10'd2, 10, st, va, vc);
      n_checks++; if (st != 0 || vc != 0) begin n_fail++; $display("FAIL illegal_cmd: got stall %0d valid %0d want 0 0", st, vc); end
      n_checks++; if (req_cyc_cnt != rq || sram_wr_cnt != sw) begin n_fail++; $display("FAIL illegal_activity: got req %0d wr %0d want 0 0", req_cyc_cnt - rq, sram_wr_cnt - sw); end
   endtask

   task automatic test_wrap;
      int st, va, vc, rb;
      rb = rd_n;
      run_cmd(2'b01, 32'hFFFF_FFFC, 32'h60, 10'd2, 10, st, va, vc);
      n_checks++; if (rd_log[rb] !== 32'hFFFF_FFFC || rd_log[rb+1] !== 32'h0) begin
         n_fail++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", rd_log[rb], rd_log[rb+1]); end
      n_checks++; if (sram_mem[24] !== 32'h1111_1111 || sram_mem[25] !== 32'h2222_2222) begin
         n_fail++; $display("FAIL wrap_data: got %h,%h want 11111111,22222222", sram_mem[24], sram_mem[25]); end
      n_checks++; if (va != 5 || vc != 1) begin n_fail++; $display("FAIL wrap_valid: got at %0d x%0d want at 5 x1", va, vc); end
   endtask

   task automatic test_reset_mid;
      int vc;
      core_write(32'hA0, 32'h0);
      core_write(32'hA4, 32'h0);
      @(negedge clk);
      bus.dmaCmd = 2'b01; bus.dmaSrcAddress = 32'h100; bus.dmaDstAddress = 32'hA0; bus.dmaWidth = 10'd3;
      @(negedge clk);
      bus.dmaCmd = 2'b00;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (bus.dramReq !== 1'b1 || bus.dramAddress !== 32'h104) begin
         n_fail++; $display("FAIL rstmid_second_req: got req %b addr %h want 1 00000104", bus.dramReq, bus.dramAddress); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (bus.stall !== 1'b0 || bus.dramReq !== 1'b0 || bus.dmaValid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_outputs: got stall %b req %b valid %b want 000", bus.stall, bus.dramReq, bus.dmaValid); end
      vc = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.dmaValid || bus.stall) vc++;
      end
      n_checks++; if (vc != 0) begin n_fail++; $display("FAIL rstmid_no_resume: got %0d active cycles want 0", vc); end
      n_checks++; if (sram_mem[40] !== 32'hA0 || sram_mem[41] !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_sram: got %h,%h want 000000a0,00000000", sram_mem[40], sram_mem[41]); end
   endtask

   task automatic test_arbitration;
      int blk;
      core_write(32'h80, 32'h55);
      n_checks++; if (sram_mem[32] !== 32'h55) begin n_fail++; $display("FAIL arb_idle_write: got %h want 00000055", sram_mem[32]); end
      core_write(32'h84, 32'h0);
      @(negedge clk);
      bus.dmaCmd = 2'b01; bus.dmaSrcAddress = 32'h100; bus.dmaDstAddress = 32'hC0; bus.dmaWidth = 10'd2;
      @(negedge clk);
      bus.dmaCmd = 2'b00;
      bus.coreSramAddress = 32'h84; bus.coreSramWriteData = 32'h77; bus.coreSramWriteEnable = 1'b1;
      #1;
      n_checks++; if (bus.sramWriteEnable !== 1'b0 || bus.sramAddress !== 32'hC0) begin
         n_fail++; $display("FAIL arb_owned: got we %b addr %h want 0 000000c0", bus.sramWriteEnable, bus.sramAddress); end
      blk = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (bus.sramWriteEnable && bus.sramWriteData === 32'h77) blk++;
      end
      bus.coreSramWriteEnable = 1'b0;
      for (int k = 0; k < 6; k++) @(negedge clk);
      n_checks++; if (sram_mem[33] !== 32'h0 || blk != 0) begin n_fail++; $display("FAIL arb_blocked: got %h leaks %0d want 00000000 0", sram_mem[33], blk); end
      n_checks++; if (sram_mem[48] !== 32'hA0 || sram_mem[49] !== 32'hA1) begin
         n_fail++; $display("FAIL arb_dma_data: got %h,%h want 000000a0,000000a1", sram_mem[48], sram_mem[49]); end
   endtask

   initial begin
      bus.dmaCmd = 2'b00; bus.dmaSrcAddress = '0; bus.dmaDstAddress = '0; bus.dmaWidth = '0;
      bus.coreSramAddress = '0; bus.coreSramWriteData = '0; bus.coreSramWriteEnable = 1'b0;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = 32'h0;
         dram_mem[i] = 32'hDEAD_0000 + i;
      end
      for (int i = 0; i < 4; i++) dram_mem[64+i] = 32'hA0 + i;
      dram_mem[255] = 32'h1111_1111;
      dram_mem[0]   = 32'h2222_2222;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_d2s();
      test_s2d();
      test_zero_and_illegal();
      test_wrap();
      test_reset_mid();
      test_arbitration();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Single-channel DMA engine that executes the core's `d2s` (DRAM→SRAM) and `s2d` (SRAM→DRAM) commands one 32-bit word at a time. It stalls the core while a transfer is in flight, takes over the shared scratchpad SRAM port from the core, and pulses `dmaValid` on completion. It sits between `mips_single`, the on-chip SRAM, and the external DRAM request port.

## Interface
- `WIDTH_BITS`, default 10: width of the word-count field `dmaWidth`.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `dmaCmd` in 2: command from the core. 00 = none, 01 = d2s, 10 = s2d, 11 = ignored.
- `dmaSrcAddress` in 32: source byte address.
- `dmaDstAddress` in 32: destination byte address.
- `dmaWidth` in WIDTH_BITS: number of words to transfer.
- `stall` out 1: holds the core's PC while a transfer is in progress.
- `dmaValid` out 1: one-cycle completion pulse.
- `coreSramAddress` in 32, `coreSramWriteData` in 32, `coreSramWriteEnable` in 1: the core's SRAM port.
- `sramAddress` out 32, `sramWriteData` out 32, `sramWriteEnable` out 1: to the SRAM.
- `sramReadData` in 32: combinational SRAM read data.
- `dramReq` out 1: DRAM request.
- `dramWe` out 1: DRAM write (1) or read (0).
- `dramAddress` out 32: DRAM byte address.
- `dramWriteData` out 32: DRAM write data.
- `dramAck` in 1: request accepted; for reads, `dramReadData` is valid in the same cycle.
- `dramReadData` in 32: DRAM read data.

## Operation
- States: IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_REQ, DONE.
- **IDLE**, when `dmaCmd` is 01 or 10:
  - Latch src, dst, `dmaWidth` as `count`, and the direction.
  - Go to D2S_REQ or S2D_RD. If `dmaWidth` = 0, go straight to DONE.
- **IDLE**, other cases: `dmaCmd` = 00 or 11 has no effect.
- **D2S_REQ**: drive `dramReq`=1, `dramWe`=0, `dramAddress`=src. Hold until `dramAck`. On ack, latch `dramReadData` and go to D2S_WR.
- **D2S_WR**: drive `sramWriteEnable`=1, `sramAddress`=dst, `sramWriteData`=latched word. Then src+=4, dst+=4, `count`-=1. Next state is DONE if `count` was 1, otherwise D2S_REQ.
- **S2D_RD**: drive `sramAddress`=src. Latch `sramReadData` and go to S2D_REQ.
- **S2D_REQ**: drive `dramReq`=1, `dramWe`=1, `dramAddress`=dst, `dramWriteData`=latched word. Hold until `dramAck`. On ack: src+=4, dst+=4, `count`-=1. Next state is DONE if `count` was 1, otherwise S2D_RD.
- **DONE**: `dmaValid`=1, `stall`=0. Go to IDLE.
- SRAM port ownership:
  - In IDLE and DONE the core's SRAM signals pass through combinationally.
  - In all other states the DMA owns the port and `sramWriteEnable` is driven only by D2S_WR.
- Address arithmetic:
  - Increments are 32-bit and wrap modulo 2^32.
  - Bits [1:0] of every emitted address are forced to 00.
- `dmaCmd` is ignored in every state except IDLE.
- While `dramReq`=1, `dramAddress`, `dramWe` and `dramWriteData` stay stable until `dramAck`.
- Reset mid-transfer:
  - Next state is IDLE; all outputs take their reset values.
  - No `dmaValid` pulse is produced.
  - Words already written stay written.

## Timing
- Reset values:
  - `stall`=0, `dmaValid`=0, `dramReq`=0, `dramWe`=0.
  - `dramAddress`=0, `dramWriteData`=0, internal `count`=0, state IDLE.
  - SRAM outputs equal the core pass-through.
- `stall` is a registered state decode: 1 in every state except IDLE and DONE. It has no combinational path from `dmaCmd`.
- Command accepted in cycle T:
  - `stall` rises at T+1.
  - In DONE, `stall` falls and `dmaValid` is 1 in the same cycle.
- Per word, with DRAM ack latency L (ack in the Lth request cycle, L≥1):
  - d2s takes L+1 cycles.
  - s2d takes L+1 cycles.
- With L=1, N words: `stall` is high for 2N cycles (T+1..T+2N), and `dmaValid` is high at T+2N+1.
- `dmaWidth`=0: DONE at T+1, so `stall` never rises.

## Test plan
- **d2s, zero wait.** Stimulus: d2s, src 0x100, dst 0x40, width 4; DRAM acks every request immediately; DRAM holds 0xA0..0xA3. Required: SRAM words 0x40..0x4C = 0xA0..0xA3; `stall` high 8 cycles; `dmaValid` one pulse at T+9.
- **s2d, L=3.** Stimulus: s2d, src 0x20, dst 0x2000, width 3. Required: DRAM writes to 0x2000/0x2004/0x2008 with SRAM data in order; request signals stable while waiting; `stall` high 12 cycles.
- **Zero width and illegal command.** Stimulus: `dmaWidth`=0. Required: no DRAM or SRAM activity, `stall` stays 0, `dmaValid` at T+1. Stimulus: `dmaCmd`=11. Required: stays IDLE, no pulse.
- **Address wrap.** Stimulus: d2s, src 0xFFFFFFFC, width 2. Required: DRAM reads 0xFFFFFFFC then 0x00000000.
- **Reset mid-transfer.** Stimulus: assert `reset` in the 2nd word's D2S_REQ. Required: next cycle IDLE, `stall`=0, `dramReq`=0, no `dmaValid`; the first word remains in SRAM.
- **Port arbitration.** Stimulus: core write 0x55 to 0x80 while IDLE. Required: it reaches the SRAM. Stimulus: core asserts `coreSramWriteEnable` during a transfer. Required: it is blocked.
